// File: rtl/lockin_pkg.sv
// Shared constants and types for the lock-in polar conversion stage.
// Phase units: a full turn is 2^32 LSB, so +pi/2 = 0x40000000 and +/-pi = 0x80000000.
package lockin_pkg;

  localparam logic [31:0] PI_2 = 32'h4000_0000;
  localparam logic [31:0] PI   = 32'h8000_0000;

  // 1/K for the CORDIC gain, unsigned Q0.32.
  localparam logic [31:0] KINV = 32'h9B74_EDA8;

  // atan(2^-i) / (2*pi) * 2^32, rounded, for i = 0..31.
  localparam logic [31:0] ATAN [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  typedef enum logic [2:0] {
    StIdle,
    StPrerot,
    StIter,
    StScale,
    StDone
  } cordic_state_e;

  // Full-width product of a non-negative magnitude (up to 96 bits) and KINV.
  function automatic logic [127:0] kinv_product(input logic [95:0] x);
    return {32'd0, x} * {96'd0, KINV};
  endfunction

endpackage

// File: rtl/cordic_vectoring_core.sv
// Iterative vectoring CORDIC: quadrant pre-rotation, ITERATIONS micro-rotations and,
// when LOCKIN_CORDIC_GAIN_COMP_EN is defined, a final multiply by 1/K (SCALE state).
// start is sampled only in StIdle; done is high for the single StDone cycle.
module cordic_vectoring_core
  import lockin_pkg::*;
#(
  parameter int unsigned ITERATIONS = 24,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAG_W      = 66
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [MAG_W-1:0]  mag,
  output logic [31:0]       phase
);

  localparam logic [4:0] LastIter = 5'(ITERATIONS - 1);

  cordic_state_e state_q, state_d;

  logic signed [MAG_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [MAG_W-1:0] x_sh, y_sh;
  logic [31:0]             z_q, z_d;
  logic [4:0]              iter_q, iter_d;
  logic                    zero_q, zero_d;

`ifdef LOCKIN_CORDIC_GAIN_COMP_EN
  logic [127:0] prod;
  assign prod = kinv_product(96'(x_q));
`endif

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign mag   = x_q;
  // A zero vector has no defined angle; report 0 instead of the accumulated table sum.
  assign phase = zero_q ? 32'd0 : z_q;

  // Next-state and datapath update for the current FSM state.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    x_sh    = x_q >>> iter_q;
    y_sh    = y_q >>> iter_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = {{(MAG_W-DATA_W){x_in[DATA_W-1]}}, x_in};
          y_d     = {{(MAG_W-DATA_W){y_in[DATA_W-1]}}, y_in};
          z_d     = 32'd0;
          iter_d  = 5'd0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = StPrerot;
        end
      end
      StPrerot: begin
        // Fold the left half-plane into the right so the rotations converge.
        if (x_q[MAG_W-1] && !y_q[MAG_W-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = PI_2;
        end else if (x_q[MAG_W-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = PI + PI_2;
        end else begin
          z_d = 32'd0;
        end
        iter_d  = 5'd0;
        state_d = StIter;
      end
      StIter: begin
        if (!y_q[MAG_W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + ATAN[iter_q];
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - ATAN[iter_q];
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == LastIter) begin
`ifdef LOCKIN_CORDIC_GAIN_COMP_EN
          state_d = StScale;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef LOCKIN_CORDIC_GAIN_COMP_EN
      StScale: begin
        x_d     = prod[MAG_W+31:32];
        state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register; enable low freezes the block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
      zero_q <= 1'b0;
    end else if (enable) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      iter_q <= iter_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: rtl/lockin_polar_cordic.sv
// Pairs X/Y filter outputs and converts them to magnitude/phase via cordic_vectoring_core.
// Optional build macro: LOCKIN_CORDIC_GAIN_COMP_EN removes the CORDIC gain from mag_out.
module lockin_polar_cordic
  import lockin_pkg::*;
#(
  parameter int unsigned ITERATIONS = 24,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAG_W      = 66
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid,
  output logic [MAG_W-1:0]  mag_out,
  output logic [31:0]       phase_out,
  output logic              out_valid,
  output logic              busy,
  output logic [15:0]       overrun_count
);

  logic [DATA_W-1:0] x_hold_q, x_hold_d, y_hold_q, y_hold_d;
  logic              x_full_q, x_full_d, y_full_q, y_full_d;
  logic [15:0]       ovr_q, ovr_d;
  logic [MAG_W-1:0]  mag_q, mag_d;
  logic [31:0]       phase_q, phase_d;
  logic              valid_q, valid_d;
  logic              launch, bump;
  logic              core_busy, core_done;
  logic [MAG_W-1:0]  core_mag;
  logic [31:0]       core_phase;

  cordic_vectoring_core #(
    .ITERATIONS (ITERATIONS),
    .DATA_W     (DATA_W),
    .MAG_W      (MAG_W)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .start   (launch),
    .x_in    (x_hold_q),
    .y_in    (y_hold_q),
    .busy    (core_busy),
    .done    (core_done),
    .mag     (core_mag),
    .phase   (core_phase)
  );

  assign busy          = core_busy;
  assign mag_out       = mag_q;
  assign phase_out     = phase_q;
  assign out_valid     = valid_q & enable;
  assign overrun_count = ovr_q;

  // Capture/pairing, overrun counting and result latching.
  always_comb begin
    launch   = enable && !core_busy && x_full_q && y_full_q;
    x_hold_d = x_hold_q;
    y_hold_d = y_hold_q;
    x_full_d = x_full_q;
    y_full_d = y_full_q;
    bump     = 1'b0;
    if (enable) begin
      if (launch) begin
        x_full_d = 1'b0;
        y_full_d = 1'b0;
      end
      // A sample landing on the launch edge refills an emptied slot, not an overrun.
      if (x_valid) begin
        x_hold_d = x_in;
        x_full_d = 1'b1;
        if (x_full_q && !launch) bump = 1'b1;
      end
      if (y_valid) begin
        y_hold_d = y_in;
        y_full_d = 1'b1;
        if (y_full_q && !launch) bump = 1'b1;
      end
    end
    ovr_d = ovr_q;
    if (bump && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
    mag_d   = mag_q;
    phase_d = phase_q;
    valid_d = 1'b0;
    if (enable && core_done) begin
      mag_d   = core_mag;
      phase_d = core_phase;
      valid_d = 1'b1;
    end
  end

  // Holding, counter and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_hold_q <= '0;
      y_hold_q <= '0;
      x_full_q <= 1'b0;
      y_full_q <= 1'b0;
      ovr_q    <= '0;
      mag_q    <= '0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      x_hold_q <= x_hold_d;
      y_hold_q <= y_hold_d;
      x_full_q <= x_full_d;
      y_full_q <= y_full_d;
      ovr_q    <= ovr_d;
      mag_q    <= mag_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_lockin_polar_cordic.sv
// Randomized and directed bench for lockin_polar_cordic against a real-arithmetic model.
module tb_lockin_polar_cordic;

  localparam int unsigned ITERATIONS = 24;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned MAG_W      = 66;
`ifdef LOCKIN_CORDIC_GAIN_COMP_EN
  localparam int LAT = ITERATIONS + 3;
`else
  localparam int LAT = ITERATIONS + 2;
`endif
  localparam real PI_R   = 3.14159265358979323846;
  localparam real TWO32  = 4294967296.0;
  localparam real TWO31  = 2147483648.0;
  localparam real TWO64  = 18446744073709551616.0;
  localparam longint P40 = 64'sd1 <<< 40;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] x_in = '0;
  logic [DATA_W-1:0] y_in = '0;
  logic              x_valid = 1'b0;
  logic              y_valid = 1'b0;
  logic [MAG_W-1:0]  mag_out;
  logic [31:0]       phase_out;
  logic              out_valid;
  logic              busy;
  logic [15:0]       overrun_count;

  int  n_vec = 0;
  int  n_miss = 0;
  int  cyc = 0;
  real gain;

  logic [MAG_W-1:0] res_mag[$];
  logic [31:0]      res_ph[$];
  int               res_cyc[$];

  lockin_polar_cordic #(
    .ITERATIONS (ITERATIONS),
    .DATA_W     (DATA_W),
    .MAG_W      (MAG_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .x_in          (x_in),
    .x_valid       (x_valid),
    .y_in          (y_in),
    .y_valid       (y_valid),
    .mag_out       (mag_out),
    .phase_out     (phase_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (out_valid) begin
      res_mag.push_back(mag_out);
      res_ph.push_back(phase_out);
      res_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input real got, input real exp, input real tol);
    n_vec++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      n_miss++;
      $display("FAIL %s: got %0.1f expected %0.1f (tol %0.1f)", tag, got, exp, tol);
    end
  endtask

  function automatic real u66_to_real(input logic [MAG_W-1:0] v);
    real hi, mid, lo;
    hi  = real'(longint'({62'd0, v[65:64]}));
    mid = real'(longint'({32'd0, v[63:32]}));
    lo  = real'(longint'({32'd0, v[31:0]}));
    return hi * TWO64 + mid * TWO32 + lo;
  endfunction

  function automatic real model_mag(input longint x, input longint y);
    real rx, ry;
    rx = real'(x);
    ry = real'(y);
    return gain * $sqrt(rx * rx + ry * ry);
  endfunction

  function automatic real model_phase(input longint x, input longint y);
    return $atan2(real'(y), real'(x)) / (2.0 * PI_R) * TWO32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit xv, input bit yv, input longint x, input longint y);
    x_valid = xv;
    y_valid = yv;
    if (xv) x_in = x;
    if (yv) y_in = y;
    tick();
    x_valid = 1'b0;
    y_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while ((res_mag.size() < n) && (k < budget)) begin
      tick();
      k++;
    end
    check("result count", real'(res_mag.size()), real'(n), 0.0);
  endtask

  task automatic check_result(input string tag, input longint x, input longint y,
                              input int exp_cyc);
    logic [MAG_W-1:0] m;
    logic [31:0]      p;
    int               c;
    real              me, pe, po;
    if (res_mag.size() == 0) return;
    m  = res_mag.pop_front();
    p  = res_ph.pop_front();
    c  = res_cyc.pop_front();
    me = model_mag(x, y);
    check({tag, " mag"}, u66_to_real(m), me, me / 1048576.0);
    pe = model_phase(x, y);
    po = real'($signed(p));
    while (po - pe > TWO31) po = po - TWO32;
    while (pe - po > TWO31) po = po + TWO32;
    check({tag, " phase"}, po, pe, 512.0);
    check({tag, " cycle"}, real'(c), real'(exp_cyc), 0.0);
  endtask

  // lead > 0: y arrives lead cycles before x; lead < 0: x first.
  task automatic run_pair(input string tag, input longint x, input longint y, input int lead);
    int c0;
    if (lead == 0) begin
      pulse(1'b1, 1'b1, x, y);
    end else if (lead > 0) begin
      pulse(1'b0, 1'b1, 0, y);
      repeat (lead - 1) tick();
      pulse(1'b1, 1'b0, x, 0);
    end else begin
      pulse(1'b1, 1'b0, x, 0);
      repeat (-lead - 1) tick();
      pulse(1'b0, 1'b1, 0, y);
    end
    c0 = cyc;
    wait_results(1, LAT + 10);
    check_result(tag, x, y, c0 + 1 + LAT);
    tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " mag"}, u66_to_real(mag_out), 0.0, 0.0);
    check({tag, " phase"}, real'(phase_out), 0.0, 0.0);
    check({tag, " valid"}, real'(out_valid), 0.0, 0.0);
    check({tag, " busy"}, real'(busy), 0.0, 0.0);
    check({tag, " ovr"}, real'(overrun_count), 0.0, 0.0);
  endtask

  initial begin
    real    k;
    longint xa, ya, xb, yb, xr, yr;
    int     ca, cy;

    k = 1.0;
    for (int i = 0; i < ITERATIONS; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
`ifdef LOCKIN_CORDIC_GAIN_COMP_EN
    gain = 1.0;
`else
    gain = k;
`endif

    enable  = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    check_cleared("reset");
    reset_n = 1'b1;
    tick();

    // Directed quadrants, zero vector and full-scale corners.
    run_pair("x+", P40, 0, 0);
    run_pair("y+", 0, P40, 0);
    run_pair("x-y-", -P40, -P40, 0);
    run_pair("x-y+", -P40, P40 >>> 2, 2);
    run_pair("x-y0", -P40, 0, -1);
    run_pair("y-", 0, -P40, 1);
    run_pair("zero", 0, 0, 0);
    check("zero mag exact", u66_to_real(mag_out), 0.0, 0.0);
    run_pair("fs min", longint'(64'h8000_0000_0000_0000),
             longint'(64'h8000_0000_0000_0000), -3);
    run_pair("fs max", longint'(64'h7FFF_FFFF_FFFF_FFFF),
             longint'(64'h7FFF_FFFF_FFFF_FFFF), 3);

    for (int i = 0; i < 12; i++) begin
      xa = longint'({$urandom, $urandom}) >>> $urandom_range(0, 20);
      ya = longint'({$urandom, $urandom}) >>> $urandom_range(0, 20);
      run_pair("random", xa, ya, int'($urandom_range(0, 6)) - 3);
    end

    // Skewed pair followed by a second pair presented while busy.
    xa = P40;
    ya = -(P40 >>> 1);
    xb = -(P40 >>> 3);
    yb = P40 >>> 1;
    pulse(1'b0, 1'b1, 0, ya);
    repeat (4) tick();
    pulse(1'b1, 1'b0, xa, 0);
    ca = cyc;
    repeat (3) tick();
    check("busy mid", real'(busy), 1.0, 0.0);
    pulse(1'b1, 1'b1, xb, yb);
    wait_results(2, 2 * LAT + 20);
    check_result("skewA", xa, ya, ca + 1 + LAT);
    check_result("skewB", xb, yb, ca + 1 + LAT + LAT + 1);
    check("skew ovr", real'(overrun_count), 0.0, 0.0);
    tick();

    // Three x samples with no y: two overwrites; the last x is used.
    pulse(1'b1, 1'b0, P40, 0);
    pulse(1'b1, 1'b0, -P40, 0);
    pulse(1'b1, 1'b0, P40 >>> 1, 0);
    pulse(1'b0, 1'b1, 0, P40 >>> 1);
    cy = cyc;
    // This x lands on the launch edge and must not count as an overrun.
    pulse(1'b1, 1'b0, -(P40 >>> 2), 0);
    wait_results(1, LAT + 10);
    check_result("ovr last x", P40 >>> 1, P40 >>> 1, cy + 1 + LAT);
    check("ovr count", real'(overrun_count), 2.0, 0.0);
    tick();
    pulse(1'b0, 1'b1, 0, -P40);
    cy = cyc;
    wait_results(1, LAT + 10);
    check_result("launch-edge x", -(P40 >>> 2), -P40, cy + 1 + LAT);
    check("ovr count 2", real'(overrun_count), 2.0, 0.0);
    tick();

    // Reset during ITER index 10 abandons the result.
    xr = P40 >>> 1;
    yr = P40;
    pulse(1'b1, 1'b1, xr, yr);
    repeat (12) tick();
    check("busy pre-reset", real'(busy), 1.0, 0.0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_cleared("mid reset");
    repeat (LAT + 5) tick();
    check("no result after reset", real'(res_mag.size()), 0.0, 0.0);
    run_pair("post reset", -P40, P40 >>> 3, 0);

    // Enable low for 7 cycles mid-ITER; the valid pulse inside the window is ignored.
    xr = P40;
    yr = P40 >>> 4;
    pulse(1'b1, 1'b1, xr, yr);
    ca = cyc;
    repeat (5) tick();
    enable = 1'b0;
    repeat (3) tick();
    pulse(1'b1, 1'b1, -P40, -P40);
    repeat (3) tick();
    enable = 1'b1;
    wait_results(1, LAT + 20);
    check_result("enable gap", xr, yr, ca + 1 + LAT + 7);
    repeat (LAT + 5) tick();
    check("no capture while disabled", real'(res_mag.size()), 0.0, 0.0);
    check("ovr after gap", real'(overrun_count), 0.0, 0.0);

    run_pair("zero end", 0, 0, 0);
    check("zero end mag exact", u66_to_real(mag_out), 0.0, 0.0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lockin_polar_cordic.md
Name: lockin_polar_cordic

Overview:
Downstream stage of the lock-in moving-average filters. Pairs the in-phase (X) and quadrature (Y) 64-bit filter outputs and converts each pair to polar form with an iterative vectoring CORDIC. Produces magnitude and phase, where phase full scale is ±pi over a 32-bit signed word. Output feeds the result FIFO/readout logic.

Parameters:
ITERATIONS, 24, number of CORDIC micro-rotations (legal 8..31)
DATA_W, 64, width of X/Y inputs (signed)
MAG_W, 66, internal datapath and magnitude width (DATA_W+2 guard bits)

Ports:
clk  in  1  clock
reset_n  in  1  reset; synchronous, active-low
enable  in  1  global enable; 0 freezes block
x_in  in  64  signed in-phase sample
x_valid  in  1  x_in qualifier, single-cycle pulse
y_in  in  64  signed quadrature sample
y_valid  in  1  y_in qualifier, single-cycle pulse
mag_out  out  66  unsigned magnitude
phase_out  out  32  signed phase; 0x40000000 = +pi/2, 0x80000000 = -pi
out_valid  out  1  one-cycle result strobe
busy  out  1  high while FSM not in IDLE
overrun_count  out  16  saturating count of overwritten unconsumed samples

Behaviour:
- Reset: mag_out=0, phase_out=0, out_valid=0, busy=0, overrun_count=0; capture registers empty; FSM=IDLE. Reset mid-computation abandons the result with no out_valid.
- enable=0: no captures, FSM and all registers hold, out_valid forced 0.
- Capture: separate X and Y holding registers, each with a full flag, accepting at all times, including while busy.
  - A valid arriving into a full register overwrites it and increments overrun_count once per cycle, saturating at 0xFFFF.
  - X and Y arriving in the same cycle, or skewed by any number of cycles, form a pair once both flags are set.
- Launch: when IDLE and both flags are set, the pair is consumed, both flags clear, and the FSM goes to PREROT. A valid arriving in the launch cycle is stored as the next sample, not counted as an overrun.
- PREROT (1 cycle): sign-extend X and Y to MAG_W, then pre-rotate:
  - x<0, y>=0: X'=Y, Y'=-X, Z=+0x40000000.
  - x<0, y<0: X'=-Y, Y'=X, Z=-0x40000000 (0xC0000000).
  - Otherwise: unchanged, Z=0.
- ITER (ITERATIONS cycles, index i=0..ITERATIONS-1):
  - If Y>=0: X+=Y>>>i, Y-=X>>>i, Z+=ATAN[i].
  - Else: X-=Y>>>i, Y+=X>>>i, Z-=ATAN[i].
  - Use arithmetic shifts. Z wraps modulo 2^32.
- DONE (1 cycle): register mag_out=X (non-negative by construction) and phase_out=Z, pulse out_valid, return to IDLE. A pending pair launches on the next cycle.
- Latency: out_valid asserts ITERATIONS+2 clk after the launch edge. Throughput is one pair per ITERATIONS+3 cycles.
- x=y=0 gives mag_out=0 and phase_out within tolerance of 0. Full-scale inputs must not overflow MAG_W.
- Accuracy: phase within ±512 LSB for ITERATIONS=24. Magnitude relative error ≤2^-20 against ideal K·sqrt(x²+y²).

Optional Feature:
- Macro: LOCKIN_CORDIC_GAIN_COMP_EN.
- Defined: add a SCALE state after ITER that multiplies X by the constant KINV=0x9B74EDA8 (0.607253 in unsigned Q0.32) and keeps the product bits [97:32]. mag_out≈sqrt(x²+y²). Latency becomes ITERATIONS+3.
- Undefined: no SCALE state; mag_out carries the CORDIC gain (≈1.64676·sqrt(x²+y²)).

Decomposition:
- Package lockin_pkg holds:
  - ATAN table, phase units atan(2^-i)/(2pi)·2^32: ATAN[0]=0x20000000, ATAN[1]=0x12E4051E, …
  - KINV.
  - Phase constants PI_2=0x40000000 and PI=0x80000000.
  - FSM state enum {IDLE, PREROT, ITER, SCALE, DONE}.
- One sub-module, cordic_vectoring_core: PREROT/ITER/SCALE datapath with start/done. The top holds pairing, overrun and output registers.

Test Plan:
- x=2^40, y=0 same cycle → after 26 cycles phase=0±512, mag=1.64676·2^40 (comp off) or 2^40 (comp on), within 2^-20 relative.
- x=0, y=2^40 → phase=0x40000000±512. x=-2^40, y=-2^40 → phase=0xA0000000±512, mag=√2·2^40 (comp on).
- y arrives 5 cycles before x, then a second pair launched while busy → two correct out_valid pulses, spaced exactly ITERATIONS+3 cycles apart, overrun_count=0.
- Three x_valid with no y_valid, then one y → overrun_count=2; the result uses the last x.
- reset_n low for 1 cycle at ITER i=10 → no out_valid, all outputs 0, next pair is computed correctly.
- enable low for 7 cycles mid-ITER → out_valid is delayed by exactly 7 cycles and the result is unchanged; x=y=0 → mag=0.
